// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared constants and types for the data-memory responder:
//            region codes, MMIO word offsets, STATUS bit positions and the
//            accelerator FSM state type.
// Ports    : none (package)
// Config   : DMEM_BUSERR_EN (used by dmem_responder, not here)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Region codes decoded from addr[19:16]
    localparam logic [3:0] RAM_REGION  = 4'h4;
    localparam logic [3:0] MMIO_REGION = 4'h5;

    // MMIO word offsets, addr[4:2]
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_OP_A   = 3'd2;
    localparam logic [2:0] OFF_OP_B   = 3'd3;
    localparam logic [2:0] OFF_MOD    = 3'd4;
    localparam logic [2:0] OFF_RESULT = 3'd5;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    // Accelerator handshake FSM
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } acc_state_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ram
// Purpose  : Byte-lane data RAM, combinational read, synchronous write with
//            a per-byte lane enable. Contents are not reset.
// Ports    : clk       - clock
//            idx_i     - word index
//            lane_we_i - byte lane write enables (bit n -> bits 8n+7:8n)
//            wdata_i   - write data, already lane-positioned
//            rdata_o   - full word at idx_i
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ram #(
    parameter int WORDS = 4096,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] idx_i,
    input  logic [3:0]    lane_we_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (lane_we_i[lane]) begin
                mem_q[idx_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule : dmem_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory port responder for the single-cycle core. Decodes
//            the region, aligns byte lanes, hosts the data RAM and an MMIO
//            register window driving the RSA accelerator start/done
//            handshake. Loads are combinational.
// Ports    : clk, rst                      - clock, sync active-high reset
//            addr_i, wdata_i, we_i, re_i   - core dmem request
//            rdata_o                       - right-justified load data
//            acc_start_o, acc_a_o, acc_b_o, acc_mod_o - accelerator request
//            acc_done_i, acc_result_i      - accelerator completion
// Config   : DMEM_BUSERR_EN - when defined, STATUS.err latches illegal
//            accesses; otherwise err reads as 0.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  we_i,
    input  logic        re_i,
    output logic [31:0] rdata_o,
    output logic        acc_start_o,
    output logic [31:0] acc_a_o,
    output logic [31:0] acc_b_o,
    output logic [31:0] acc_mod_o,
    input  logic        acc_done_i,
    input  logic [31:0] acc_result_i
);

    localparam int AW = $clog2(RAM_WORDS);

    acc_state_e  state_q, state_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] mod_q, mod_d;
    logic [31:0] result_q, result_d;
    logic        w_err;

    // ---------------- decode ----------------
    logic        w_is_ram, w_is_mmio, w_unmapped;
    logic [1:0]  w_off;
    logic [2:0]  w_sel;
    logic [3:0]  w_lane_we;
    logic        w_misaligned, w_store, w_mmio_wr;

    assign w_is_ram   = (addr_i[19:16] == RAM_REGION);
    assign w_is_mmio  = (addr_i[19:16] == MMIO_REGION);
    assign w_unmapped = !w_is_ram && !w_is_mmio;
    assign w_off      = addr_i[1:0];
    assign w_sel      = addr_i[4:2];
    assign w_store    = (we_i != 4'b0000);
    // Lanes past bit 3 fall off; the only masks that would spill are the
    // misaligned SH/SW cases, which are dropped anyway.
    assign w_lane_we  = we_i << w_off;
    assign w_misaligned = ((we_i == 4'b0011) && w_off[0]) ||
                          ((we_i == 4'b1111) && (w_off != 2'b00));
    assign w_mmio_wr  = w_is_mmio && (we_i == 4'b1111) && !w_misaligned;

    // ---------------- RAM ----------------
    logic [31:0] w_ram_rdata;
    logic [3:0]  w_ram_we;

    assign w_ram_we = (w_is_ram && !w_misaligned) ? w_lane_we : 4'b0000;

    dmem_ram #(
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .idx_i     (addr_i[AW+1:2]),
        .lane_we_i (w_ram_we),
        .wdata_i   (wdata_i),
        .rdata_o   (w_ram_rdata)
    );

    // ---------------- read path ----------------
    logic [31:0] w_status, w_mmio_rdata, w_word;

    assign w_status = {29'd0, w_err, done_q, (state_q == ST_BUSY)};

    always_comb begin
        w_mmio_rdata = 32'd0;
        case (w_sel)
            OFF_STATUS: w_mmio_rdata = w_status;
            OFF_OP_A:   w_mmio_rdata = opa_q;
            OFF_OP_B:   w_mmio_rdata = opb_q;
            OFF_MOD:    w_mmio_rdata = mod_q;
            OFF_RESULT: w_mmio_rdata = result_q;
            default:    w_mmio_rdata = 32'd0;
        endcase
    end

    assign w_word  = w_is_ram ? w_ram_rdata : (w_is_mmio ? w_mmio_rdata : 32'd0);
    assign rdata_o = w_word >> {w_off, 3'b000};

    // ---------------- MMIO registers + FSM ----------------
    logic w_stat_wr, w_start_req;

    assign w_stat_wr   = w_mmio_wr && (w_sel == OFF_STATUS);
    assign w_start_req = w_mmio_wr && (w_sel == OFF_CTRL) && wdata_i[0];

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        done_d   = done_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        mod_d    = mod_q;
        result_d = result_q;

        if (w_stat_wr && wdata_i[STAT_DONE]) begin
            done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_mmio_wr) begin
                    case (w_sel)
                        OFF_OP_A: opa_d = wdata_i;
                        OFF_OP_B: opb_d = wdata_i;
                        OFF_MOD:  mod_d = wdata_i;
                        default:  ;
                    endcase
                end
                if (w_start_req) begin
                    state_d = ST_BUSY;
                    start_d = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_BUSY: begin
                // Completion overrides a same-cycle W1C of done.
                if (acc_done_i) begin
                    state_d  = ST_IDLE;
                    result_d = acc_result_i;
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            mod_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            done_q   <= done_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            mod_q    <= mod_d;
            result_q <= result_d;
        end
    end

`ifdef DMEM_BUSERR_EN
    logic err_q, err_d;
    logic w_bus_err;

    assign w_bus_err = (w_unmapped && (w_store || re_i)) ||
                       (w_store && w_misaligned) ||
                       (w_is_mmio && w_store && (we_i != 4'b1111));

    always_comb begin
        err_d = err_q;
        if (w_stat_wr && wdata_i[STAT_ERR]) begin
            err_d = 1'b0;
        end
        if (w_bus_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign w_err = err_q;
`else
    assign w_err = 1'b0;
`endif

    assign acc_start_o = start_q;
    assign acc_a_o     = opa_q;
    assign acc_b_o     = opb_q;
    assign acc_mod_o   = mod_q;

    // Address bits outside the decoded fields, and re_i when the error
    // logic is compiled out, are intentionally ignored.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, addr_i[31:20], addr_i[15:5], re_i, w_unmapped};

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder: directed steps, expected
//            values queued when stimulus is driven, popped at each check.
// Config   : DMEM_BUSERR_EN changes the expected STATUS.err values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [31:0] A_CTRL   = 32'h0005_0000;
    localparam logic [31:0] A_STATUS = 32'h0005_0004;
    localparam logic [31:0] A_OPA    = 32'h0005_0008;
    localparam logic [31:0] A_OPB    = 32'h0005_000C;
    localparam logic [31:0] A_MOD    = 32'h0005_0010;
    localparam logic [31:0] A_RESULT = 32'h0005_0014;
`ifdef DMEM_BUSERR_EN
    localparam logic [31:0] ERRV = 32'h4;
`else
    localparam logic [31:0] ERRV = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  we;
    logic        re;
    logic        acc_start, acc_done;
    logic [31:0] acc_a, acc_b, acc_mod, acc_result;

    int          total = 0;
    int          bad   = 0;
    int          start_cnt = 0;
    logic [31:0] exp_q[$];

    dmem_responder #(.RAM_WORDS(4096)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .we_i         (we),
        .re_i         (re),
        .rdata_o      (rdata),
        .acc_start_o  (acc_start),
        .acc_a_o      (acc_a),
        .acc_b_o      (acc_b),
        .acc_mod_o    (acc_mod),
        .acc_done_i   (acc_done),
        .acc_result_i (acc_result)
    );

    always #5 clk = ~clk;

    // Count cycles in which acc_start is high, sampled mid-cycle.
    always @(negedge clk) if (acc_start === 1'b1) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr = a; wdata = d; we = m; re = 1'b0;
        @(posedge clk);
        #1;
        we = 4'b0000;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        addr = a; we = 4'b0000; re = 1'b1;
        #1;
        chk(tag, rdata);
        @(posedge clk);
        #1;
        re = 1'b0;
    endtask

    task automatic pulse_done(input logic [31:0] r);
        @(negedge clk);
        acc_done = 1'b1; acc_result = r;
        @(posedge clk);
        #1;
        acc_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 4'b0; re = 1'b0;
        acc_done = 1'b0; acc_result = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        exp_q.push_back(32'h0); chk("rst_acc_start", {31'd0, acc_start});
        exp_q.push_back(32'h0); chk("rst_acc_a", acc_a);
        rd("rst_status", A_STATUS, 32'h0);
        rd("rst_result", A_RESULT, 32'h0);

        // Word RAM access, shifted load, aliasing
        wr(32'h0004_0010, 32'hDEAD_BEEF, 4'b1111);
        rd("lw_word", 32'h0004_0010, 32'hDEAD_BEEF);
        rd("lw_off3", 32'h0004_0013, 32'h0000_00DE);
        rd("lw_alias", 32'h0004_4010, 32'hDEAD_BEEF);

        // Byte store over a zero word
        wr(32'h0004_0010, 32'h0000_0000, 4'b1111);
        wr(32'h0004_0012, 32'h5A5A_5A5A, 4'b0001);
        rd("sb_word", 32'h0004_0010, 32'h005A_0000);

        // Unmapped load returns 0
        rd("unmapped_rd", 32'h0003_0010, 32'h0);

        // Misaligned halfword store is dropped
        wr(32'h0004_0011, 32'h1234_1234, 4'b0011);
        rd("sh_misal_word", 32'h0004_0010, 32'h005A_0000);
        rd("sh_misal_status", A_STATUS, ERRV);
        wr(A_STATUS, 32'h0000_0006, 4'b1111);
        rd("w1c_status", A_STATUS, 32'h0);

        // Aligned upper halfword store and misaligned word load
        wr(32'h0004_0012, 32'hBEEF_BEEF, 4'b0011);
        rd("sh_hi_word", 32'h0004_0010, 32'hBEEF_0000);
        rd("lw_misal", 32'h0004_0011, 32'h00BE_EF00);

        // Accelerator handshake
        wr(A_OPA, 32'd3, 4'b1111);
        wr(A_OPB, 32'd5, 4'b1111);
        wr(A_MOD, 32'd7, 4'b1111);
        wr(A_OPA, 32'h0000_00FF, 4'b0001);   // partial MMIO write dropped
        rd("opa_rd", A_OPA, 32'd3);
        exp_q.push_back(32'd5); chk("acc_b", acc_b);
        exp_q.push_back(32'd7); chk("acc_mod", acc_mod);
        wr(A_CTRL, 32'h1, 4'b1111);
        exp_q.push_back(32'h1); chk("acc_start_hi", {31'd0, acc_start});
        rd("busy_status", A_STATUS, 32'h1 | ERRV);
        exp_q.push_back(32'h0); chk("acc_start_lo", {31'd0, acc_start});
        exp_q.push_back(32'd1); chk("start_once", start_cnt);

        // Writes while busy are ignored
        wr(A_OPA, 32'd9, 4'b1111);
        wr(A_CTRL, 32'h1, 4'b1111);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'd3); chk("busy_acc_a", acc_a);
        exp_q.push_back(32'd1); chk("busy_no_restart", start_cnt);

        // Completion
        pulse_done(32'h5);
        rd("done_status", A_STATUS, 32'h2 | ERRV);
        rd("done_result", A_RESULT, 32'h5);

        // acc_done in IDLE is ignored
        pulse_done(32'h99);
        rd("idle_done_result", A_RESULT, 32'h5);

        // Reset mid-run
        wr(A_STATUS, 32'h0000_0006, 4'b1111);
        wr(A_CTRL, 32'h1, 4'b1111);
        rd("rerun_status", A_STATUS, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_done(32'h77);
        rd("rst_run_status", A_STATUS, 32'h0);
        rd("rst_run_result", A_RESULT, 32'h0);
        exp_q.push_back(32'h0); chk("rst_run_acc_a", acc_a);
        rd("ram_kept", 32'h0004_0010, 32'hBEEF_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
